// File: rtl/gray_sync_decoder.sv
// Synchronises a Gray-coded count into clk_i, converts it to binary and reports single-code steps.
// Optional multi-bit transition checking (sticky err_o, clr_err_i) is built when GRAY_SYNC_ERR_CHK_EN is defined.
module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] gray_sync_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             step_o,
  output logic             dir_o,
  output logic             err_o
);

  localparam int WARM_CYCLES = SYNC_STAGES + 1;
  localparam int CNT_W       = $clog2(WARM_CYCLES + 1);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [WIDTH-1:0] prev_gray_reg;
  logic [WIDTH-1:0] bin_reg;
  logic             step_reg;
  logic             dir_reg;
  logic [CNT_W-1:0] warm_cnt_reg;

  logic [WIDTH-1:0] gray_now;
  logic [WIDTH-1:0] bin_now;
  logic [WIDTH-1:0] diff;
  logic             one_bit;
  logic             warm_done;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_reg[gi] <= '0;
          else         sync_reg[gi] <= gray_i;
        end
      end else begin : g_rest
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_reg[gi] <= '0;
          else         sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign gray_now  = sync_reg[SYNC_STAGES-1];
  assign bin_now   = gray2bin(gray_now);
  assign diff      = gray_now ^ prev_gray_reg;
  assign one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  assign warm_done = (warm_cnt_reg == CNT_W'(WARM_CYCLES));

  // bin_reg always equals gray2bin(prev_gray_reg), so it serves as the old binary value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_gray_reg <= '0;
      bin_reg       <= '0;
      step_reg      <= 1'b0;
      dir_reg       <= 1'b0;
      warm_cnt_reg  <= '0;
    end else begin
      prev_gray_reg <= gray_now;
      bin_reg       <= bin_now;
      step_reg      <= warm_done && one_bit;
      if (!warm_done) warm_cnt_reg <= warm_cnt_reg + CNT_W'(1);
      if (warm_done && one_bit) dir_reg <= (bin_now == bin_reg + WIDTH'(1));
    end
  end

`ifdef GRAY_SYNC_ERR_CHK_EN
  logic multi_bit;
  logic err_reg;

  assign multi_bit = ((diff & (diff - WIDTH'(1))) != '0);

  // a fresh error in the clearing cycle takes priority over the clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     err_reg <= 1'b0;
    else if (clr_err_i)              err_reg <= warm_done && multi_bit;
    else if (warm_done && multi_bit) err_reg <= 1'b1;
  end

  assign err_o = err_reg;
`else
  logic unused_clr;
  assign unused_clr = clr_err_i;
  assign err_o      = 1'b0;
`endif

  assign gray_sync_o = gray_now;
  assign bin_o       = bin_reg;
  assign step_o      = step_reg;
  assign dir_o       = dir_reg;

endmodule
